hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core. It generates per-stage enable, flush and bubble controls around the decode stage.
- Handles four events: load-use stalls, EX-resolved redirects (flush), data-memory wait (global freeze), and serializing instructions (fence/CSR), which must drain EX/MEM/WB before issuing.
- Sits beside the ID stage. Outputs drive the PC register, the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and two saturating perf counters.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/sat_counter.sv | 34 +++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: register-file address width and hazard controller state encoding.
package riscv_pkg;

   localparam int REG_ADDR_WIDTH = 5;

   typedef enum logic {
      HZ_RUN,
      HZ_DRAIN
   } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing around ID: load-use stalls, redirect flushes, dmem freeze and
// serializing-instruction drain. Controls are combinational from state and inputs.
module hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
   input  logic                      id_uses_rs1,
   input  logic                      id_uses_rs2,
   input  logic                      id_serialize,
   input  logic                      ex_valid,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
   input  logic                      ex_mem_read,
   input  logic                      ex_redirect,
   input  logic                      mem_valid,
   input  logic                      wb_valid,
   input  logic                      dmem_wait,
   input  logic                      perf_clr,
   output logic                      pc_en,
   output logic                      if_id_en,
   output logic                      if_id_flush,
   output logic                      id_ex_en,
   output logic                      id_ex_bubble,
   output logic                      ex_mem_en,
   output logic                      mem_wb_en,
   output logic                      drain_active,
   output logic [CNT_WIDTH-1:0]      stall_count,
   output logic [CNT_WIDTH-1:0]      flush_count
);

   hz_state_t state_q;
   hz_state_t state_d;

   logic load_use;
   logic pipe_empty;
   logic flush_inc;
   logic stall_inc;

   assign load_use = ex_valid && ex_mem_read && (ex_rd_addr != '0) && id_valid &&
                     ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                      (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

   assign pipe_empty = !ex_valid && !mem_valid && !wb_valid;

   always_comb begin
      state_d      = state_q;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b1;
      id_ex_bubble = 1'b0;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      flush_inc    = 1'b0;

      if (!reset) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else if (dmem_wait) begin
         // Whole pipe frozen; a pending redirect is re-presented once MEM completes.
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else if (ex_redirect) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         flush_inc    = 1'b1;
         state_d      = HZ_RUN;
      end else if (state_q == HZ_DRAIN) begin
         if (!pipe_empty) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
         end else begin
            state_d = HZ_RUN;
         end
      end else if (id_valid && id_serialize && !pipe_empty) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_bubble = 1'b1;
         state_d      = HZ_DRAIN;
      end else if (load_use) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= HZ_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign drain_active = reset && (state_q == HZ_DRAIN);
   assign stall_inc    = reset && !pc_en;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (perf_clr),
      .inc   (stall_inc),
      .count (stall_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (perf_clr),
      .inc   (flush_inc),
      .count (flush_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl built with 4-bit perf counters so saturation is reachable.
module tb_hazard_ctrl;
   import riscv_pkg::*;

   localparam int CW = 4;

   logic clk;
   logic reset;
   logic id_valid, id_uses_rs1, id_uses_rs2, id_serialize;
   logic [REG_ADDR_WIDTH-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic ex_valid, ex_mem_read, ex_redirect, mem_valid, wb_valid, dmem_wait, perf_clr;
   logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en;
   logic drain_active;
   logic [CW-1:0] stall_count, flush_count;

   int errors = 0;
   int checks = 0;

   hazard_ctrl #(.CNT_WIDTH(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_rs1_addr  (id_rs1_addr),
      .id_rs2_addr  (id_rs2_addr),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .id_serialize (id_serialize),
      .ex_valid     (ex_valid),
      .ex_rd_addr   (ex_rd_addr),
      .ex_mem_read  (ex_mem_read),
      .ex_redirect  (ex_redirect),
      .mem_valid    (mem_valid),
      .wb_valid     (wb_valid),
      .dmem_wait    (dmem_wait),
      .perf_clr     (perf_clr),
      .pc_en        (pc_en),
      .if_id_en     (if_id_en),
      .if_id_flush  (if_id_flush),
      .id_ex_en     (id_ex_en),
      .id_ex_bubble (id_ex_bubble),
      .ex_mem_en    (ex_mem_en),
      .mem_wb_en    (mem_wb_en),
      .drain_active (drain_active),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected control word: {pc, if_id, flush, id_ex, bubble, ex_mem, mem_wb}
   typedef struct {
      string                     name;
      logic                      idv;
      logic [REG_ADDR_WIDTH-1:0] rs1;
      logic [REG_ADDR_WIDTH-1:0] rs2;
      logic                      u1;
      logic                      u2;
      logic                      ser;
      logic                      exv;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      ld;
      logic                      redir;
      logic                      memv;
      logic                      wbv;
      logic                      dw;
      logic [6:0]                exp;
   } vec_t;

   localparam logic [6:0] ALL_ON = 7'b1101011;
   localparam logic [6:0] STALL  = 7'b0001111;
   localparam logic [6:0] FLUSH  = 7'b1111111;
   localparam logic [6:0] FROZEN = 7'b0000000;

   vec_t vecs[12];

   function automatic vec_t mk(string n, logic idv, logic [4:0] rs1, logic [4:0] rs2,
                               logic u1, logic u2, logic ser, logic exv, logic [4:0] rd,
                               logic ld, logic redir, logic memv, logic wbv, logic dw,
                               logic [6:0] exp);
      vec_t v;
      v.name = n; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
      v.ser = ser; v.exv = exv; v.rd = rd; v.ld = ld; v.redir = redir;
      v.memv = memv; v.wbv = wbv; v.dw = dw; v.exp = exp;
      return v;
   endfunction

   function automatic logic [6:0] ctl();
      return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      id_valid = v.idv; id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
      id_uses_rs1 = v.u1; id_uses_rs2 = v.u2; id_serialize = v.ser;
      ex_valid = v.exv; ex_rd_addr = v.rd; ex_mem_read = v.ld; ex_redirect = v.redir;
      mem_valid = v.memv; wb_valid = v.wbv; dmem_wait = v.dw;
   endtask

   task automatic idle();
      id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      id_serialize = 0; ex_valid = 0; ex_rd_addr = 0; ex_mem_read = 0; ex_redirect = 0;
      mem_valid = 0; wb_valid = 0; dmem_wait = 0; perf_clr = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counters();
      idle();
      perf_clr = 1;
      tick();
      perf_clr = 0;
   endtask

   initial begin
      vecs[0]  = mk("lu_rs1",      1, 5, 0, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, STALL);
      vecs[1]  = mk("lu_rs2",      1, 3, 7, 1, 1, 0, 1, 7, 1, 0, 1, 1, 0, STALL);
      vecs[2]  = mk("x0_load",     1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, ALL_ON);
      vecs[3]  = mk("rs2_unused",  1, 1, 9, 1, 0, 0, 1, 9, 1, 0, 0, 0, 0, ALL_ON);
      vecs[4]  = mk("not_load",    1, 5, 0, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0, ALL_ON);
      vecs[5]  = mk("ex_invalid",  1, 5, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, ALL_ON);
      vecs[6]  = mk("id_invalid",  0, 5, 0, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, ALL_ON);
      vecs[7]  = mk("redir_lu",    1, 5, 0, 1, 0, 0, 1, 5, 1, 1, 0, 0, 0, FLUSH);
      vecs[8]  = mk("dwait_lu",    1, 5, 0, 1, 0, 0, 1, 5, 1, 0, 0, 0, 1, FROZEN);
      vecs[9]  = mk("dwait_redir", 1, 2, 0, 1, 0, 0, 1, 4, 0, 1, 1, 1, 1, FROZEN);
      vecs[10] = mk("ser_empty",   1, 2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, ALL_ON);
      vecs[11] = mk("redir_only",  1, 2, 0, 1, 0, 0, 1, 4, 0, 1, 1, 0, 0, FLUSH);

      // Reset: inputs that would otherwise enable everything
      idle();
      reset = 0;
      #12;
      chk("rst_ctl", 32'(ctl()), 32'(FROZEN));
      chk("rst_drain", 32'(drain_active), 0);
      chk("rst_stall_cnt", 32'(stall_count), 0);
      chk("rst_flush_cnt", 32'(flush_count), 0);
      @(negedge clk);
      reset = 1;
      tick();
      chk("post_rst_ctl", 32'(ctl()), 32'(ALL_ON));

      foreach (vecs[i]) begin
         drive(vecs[i]);
         #1;
         chk({"vec_", vecs[i].name}, 32'(ctl()), 32'(vecs[i].exp));
         chk({"vec_drain_", vecs[i].name}, 32'(drain_active), 0);
         tick();
      end

      // Load-use lasts one cycle: the load moves on and ID proceeds
      clear_counters();
      drive(vecs[0]);
      #1;
      chk("lu_c1_pc", 32'(pc_en), 0);
      tick();
      ex_valid = 0; ex_mem_read = 0; mem_valid = 1;
      #1;
      chk("lu_c2_ctl", 32'(ctl()), 32'(ALL_ON));
      tick();
      idle();
      chk("lu_stall_cnt", 32'(stall_count), 1);

      // Redirect coincident with load-use
      clear_counters();
      drive(vecs[7]);
      tick();
      idle();
      chk("redir_flush_cnt", 32'(flush_count), 1);
      chk("redir_stall_cnt", 32'(stall_count), 0);

      // Serialize drain: downstream valids clear one per cycle
      clear_counters();
      id_valid = 1; id_serialize = 1; ex_valid = 1; mem_valid = 1; wb_valid = 1;
      #1;
      chk("ser_c1_ctl", 32'(ctl()), 32'(STALL));
      chk("ser_c1_drain", 32'(drain_active), 0);
      tick();
      ex_valid = 0;
      #1;
      chk("ser_c2_ctl", 32'(ctl()), 32'(STALL));
      chk("ser_c2_drain", 32'(drain_active), 1);
      tick();
      mem_valid = 0;
      #1;
      chk("ser_c3_ctl", 32'(ctl()), 32'(STALL));
      chk("ser_c3_drain", 32'(drain_active), 1);
      tick();
      wb_valid = 0;
      #1;
      chk("ser_c4_issue", 32'(ctl()), 32'(ALL_ON));
      chk("ser_c4_drain", 32'(drain_active), 1);
      tick();
      idle();
      #1;
      chk("ser_c5_drain", 32'(drain_active), 0);
      chk("ser_stall_cnt", 32'(stall_count), 3);

      // Redirect while draining discards the serialized instruction
      id_valid = 1; id_serialize = 1; ex_valid = 1;
      tick();
      #1;
      chk("ser_redir_in_drain", 32'(drain_active), 1);
      ex_redirect = 1;
      #1;
      chk("ser_redir_ctl", 32'(ctl()), 32'(FLUSH));
      tick();
      idle();
      #1;
      chk("ser_redir_exit", 32'(drain_active), 0);

      // dmem_wait holds a pending redirect for 4 cycles
      clear_counters();
      ex_valid = 1; ex_redirect = 1; dmem_wait = 1; mem_valid = 1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("dw_freeze_c%0d", c), 32'(ctl()), 32'(FROZEN));
         tick();
      end
      dmem_wait = 0;
      #1;
      chk("dw_flush_c5", 32'(ctl()), 32'(FLUSH));
      tick();
      idle();
      chk("dw_flush_cnt", 32'(flush_count), 1);
      chk("dw_stall_cnt", 32'(stall_count), 4);

      // Stall counter saturation, then clear with a stall still present
      clear_counters();
      drive(vecs[0]);
      for (int c = 0; c < 17; c++) tick();
      chk("sat_stall_cnt", 32'(stall_count), 15);
      perf_clr = 1;
      tick();
      perf_clr = 0;
      idle();
      chk("clr_stall_cnt", 32'(stall_count), 0);

      // Asynchronous reset mid-drain
      id_valid = 1; id_serialize = 1; ex_valid = 1;
      tick();
      tick();
      chk("mid_drain_active", 32'(drain_active), 1);
      chk("mid_drain_cnt", 32'(stall_count), 2);
      #2;
      reset = 0;
      #1;
      chk("rst_mid_drain", 32'(drain_active), 0);
      chk("rst_mid_ctl", 32'(ctl()), 32'(FROZEN));
      chk("rst_mid_cnt", 32'(stall_count), 0);
      idle();
      @(negedge clk);
      reset = 1;
      tick();
      chk("rst_mid_after", 32'(ctl()), 32'(ALL_ON));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
